inst_fetch_queue: RTL and testbench

//  Fetch sequencer feeding the decoder. Issues one-at-a-time I-cache requests and buffers returned

---
 rtl/inst_fetch_queue.sv | 172 +++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Fetch sequencer: one outstanding I-cache request at a time, a small instruction queue with
// static branch prediction, and a full squash of in-flight and buffered work on ROB redirect.
module inst_fetch_queue #(
  parameter int unsigned IQ_ADDR  = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_valid,
  input  logic [31:0] ic_instr,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_isjump,
  input  logic        out_stall,
  input  logic        flush_in,
  input  logic [31:0] flush_pc
);

  localparam int unsigned DEPTH = 1 << IQ_ADDR;
  localparam int unsigned CNT_W = IQ_ADDR + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic               ic_req_q, ic_req_d;
  logic [31:0]        ic_addr_q, ic_addr_d;
  logic [IQ_ADDR-1:0] head_q, head_d;
  logic [IQ_ADDR-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];
  logic        jump_mem  [DEPTH];

  logic        push_c;
  logic        pop_c;
  logic        pred_jump_c;
  logic [31:0] pred_next_c;
  logic [6:0]  opcode_c;
  logic [31:0] imm_j_c;
  logic [31:0] imm_b_c;

  // Static prediction on the returning word: jal and backward branches are taken.
  assign opcode_c = ic_instr[6:0];
  assign imm_j_c  = {{11{ic_instr[31]}}, ic_instr[31], ic_instr[19:12], ic_instr[20],
                     ic_instr[30:21], 1'b0};
  assign imm_b_c  = {{19{ic_instr[31]}}, ic_instr[31], ic_instr[7], ic_instr[30:25],
                     ic_instr[11:8], 1'b0};

  always_comb begin
    pred_jump_c = 1'b0;
    pred_next_c = ic_addr_q + 32'd4;
    if (opcode_c == 7'b1101111) begin
      pred_jump_c = 1'b1;
      pred_next_c = ic_addr_q + imm_j_c;
    end else if (opcode_c == 7'b1100011 && ic_instr[31]) begin
      pred_jump_c = 1'b1;
      pred_next_c = ic_addr_q + imm_b_c;
    end
  end

  assign out_valid  = (count_q != '0) && !flush_in;
  assign out_instr  = instr_mem[head_q];
  assign out_pc     = pc_mem[head_q];
  assign out_isjump = jump_mem[head_q];
  assign pop_c      = rdy_in && out_valid && !out_stall;

  assign ic_req  = ic_req_q;
  assign ic_addr = ic_addr_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    ic_req_d   = ic_req_q;
    ic_addr_d  = ic_addr_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    push_c     = 1'b0;
    if (rdy_in) begin
      if (flush_in) begin
        // Redirect: drop the queue; an outstanding request is still held until its data returns.
        fetch_pc_d = flush_pc;
        head_d     = '0;
        tail_d     = '0;
        count_d    = '0;
        case (state_q)
          S_WAIT, S_DRAIN: begin
            if (ic_valid) begin
              ic_req_d = 1'b0;
              state_d  = S_IDLE;
            end else begin
              state_d  = S_DRAIN;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end else begin
        case (state_q)
          S_IDLE: begin
            if (count_q < CNT_W'(DEPTH)) begin
              ic_req_d  = 1'b1;
              ic_addr_d = fetch_pc_q;
              state_d   = S_WAIT;
            end
          end
          S_WAIT: begin
            if (ic_valid) begin
              push_c     = 1'b1;
              fetch_pc_d = pred_next_c;
              ic_req_d   = 1'b0;
              state_d    = S_IDLE;
            end
          end
          S_DRAIN: begin
            if (ic_valid) begin
              ic_req_d = 1'b0;
              state_d  = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase
        if (push_c) tail_d = tail_q + IQ_ADDR'(1);
        if (pop_c)  head_d = head_q + IQ_ADDR'(1);
        case ({push_c, pop_c})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      ic_req_q   <= 1'b0;
      ic_addr_q  <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      ic_req_q   <= ic_req_d;
      ic_addr_q  <= ic_addr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Queue storage carries no reset; count_q alone says which entries are live.
  always_ff @(posedge clk_in) begin
    if (push_c) begin
      instr_mem[tail_q] <= ic_instr;
      pc_mem[tail_q]    <= ic_addr_q;
      jump_mem[tail_q]  <= pred_jump_c;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: directed programs, a latency-configurable I-cache
// model, and monitors checking request addresses and decoder-side pops against expected queues.
module tb_inst_fetch_queue;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        jmp;
  } out_t;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_valid;
  logic [31:0] ic_instr;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_isjump;
  logic        out_stall;
  logic        flush_in;
  logic [31:0] flush_pc;

  logic [31:0] mem [1024];
  int          lat;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_req [$];
  out_t        exp_out [$];
  logic        prev_req;

  localparam logic [31:0] JAL_P20  = 32'h0200006F;
  localparam logic [31:0] BEQ_M8   = 32'hFE000CE3;
  localparam logic [31:0] BNE_P16  = 32'h00001863;

  inst_fetch_queue #(.IQ_ADDR(2), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_instr(ic_instr),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_isjump(out_isjump),
    .out_stall(out_stall), .flush_in(flush_in), .flush_pc(flush_pc)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // I-cache model: latches a request, answers with a one-cycle ic_valid pulse lat cycles later.
  initial begin
    logic        busy;
    int          cnt;
    logic [31:0] addr;
    busy = 1'b0; cnt = 0; addr = '0;
    ic_valid = 1'b0;
    ic_instr = '0;
    forever begin
      @(posedge clk_in); #1;
      if (rst_in) begin
        ic_valid = 1'b0;
        busy     = 1'b0;
      end else if (rdy_in) begin
        if (ic_valid) begin
          ic_valid = 1'b0;
        end else if (busy) begin
          cnt--;
          if (cnt == 0) begin
            ic_valid = 1'b1;
            ic_instr = mem[addr[11:2]];
            busy     = 1'b0;
          end
        end else if (ic_req) begin
          busy = 1'b1;
          cnt  = lat;
          addr = ic_addr;
        end
      end
    end
  end

  // Monitor: new requests and decoder pops are checked against the expected queues.
  always @(negedge clk_in) begin
    if (rst_in) begin
      prev_req = 1'b0;
    end else begin
      if (ic_req && !prev_req && exp_req.size() != 0)
        chk("req_addr", ic_addr, exp_req.pop_front());
      prev_req = ic_req;
      if (out_valid && !out_stall && rdy_in && exp_out.size() != 0) begin
        out_t e;
        e = exp_out.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_instr", out_instr, e.instr);
        chk("out_isjump", 32'(out_isjump), 32'(e.jmp));
      end
    end
  end

  task automatic init_mem();
    for (int i = 0; i < 1024; i++) mem[i] = {12'(i), 5'd0, 3'd0, 5'd1, 7'h13};
  endtask

  task automatic er(input logic [31:0] a);
    exp_req.push_back(a);
  endtask

  task automatic eo(input logic [31:0] a, input logic j);
    out_t e;
    e.pc = a; e.instr = mem[a[11:2]]; e.jmp = j;
    exp_out.push_back(e);
  endtask

  task automatic do_reset(input int l);
    rst_in = 1'b1;
    #1;
    chk("rst_ic_req", 32'(ic_req), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ic_addr", ic_addr, 32'h0);
    lat = l;
    exp_req.delete();
    exp_out.delete();
    repeat (3) @(posedge clk_in);
    #2 rst_in = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && (exp_req.size() != 0 || exp_out.size() != 0); i++)
      @(negedge clk_in);
    chk({name, "_req_left"}, 32'(exp_req.size()), 32'd0);
    chk({name, "_out_left"}, 32'(exp_out.size()), 32'd0);
  endtask

  task automatic wait_req(input logic [31:0] a, input string name);
    int n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!(ic_req && ic_addr == a && !ic_valid) && n < 300);
    if (n >= 300) timeout(name);
  endtask

  task automatic wait_valid(input logic [31:0] a, input string name);
    int n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!(ic_req && ic_valid && ic_addr == a) && n < 300);
    if (n >= 300) timeout(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; out_stall = 1'b0; flush_in = 1'b0; flush_pc = '0;
    lat = 2;

    // Straight-line addi stream
    init_mem();
    do_reset(2);
    for (int a = 0; a <= 'h14; a += 4) begin er(32'(a)); eo(32'(a), 1'b0); end
    drain("t1");

    // jal at 0x10 redirects to 0x30
    init_mem();
    mem['h10 >> 2] = JAL_P20;
    do_reset(2);
    for (int a = 0; a <= 'h10; a += 4) begin er(32'(a)); eo(32'(a), a == 'h10); end
    er(32'h30); eo(32'h30, 1'b0);
    er(32'h34); eo(32'h34, 1'b0);
    drain("t2");

    // Backward beq at 0x40 loops to 0x38
    init_mem();
    mem['h40 >> 2] = BEQ_M8;
    do_reset(2);
    for (int a = 0; a <= 'h40; a += 4) begin er(32'(a)); eo(32'(a), a == 'h40); end
    er(32'h38); eo(32'h38, 1'b0);
    er(32'h3C); eo(32'h3C, 1'b0);
    er(32'h40); eo(32'h40, 1'b1);
    er(32'h38); eo(32'h38, 1'b0);
    drain("t3a");

    // Forward bne at 0x80 falls through; reached via a flush while idle
    init_mem();
    mem['h80 >> 2] = BNE_P16;
    flush_in = 1'b1; flush_pc = 32'h80;
    do_reset(2);
    @(posedge clk_in); #2 flush_in = 1'b0;
    @(negedge clk_in);
    chk("t3b_no_req_in_flush", 32'(ic_req), 32'd0);
    er(32'h80); eo(32'h80, 1'b0);
    er(32'h84); eo(32'h84, 1'b0);
    er(32'h88); eo(32'h88, 1'b0);
    drain("t3b");

    // Decoder stalled from reset: queue fills, then four back-to-back pops
    init_mem();
    out_stall = 1'b1;
    do_reset(2);
    for (int a = 0; a <= 'h10; a += 4) begin er(32'(a)); eo(32'(a), 1'b0); end
    repeat (30) @(negedge clk_in);
    chk("t4_full_no_req", 32'(ic_req), 32'd0);
    chk("t4_full_valid", 32'(out_valid), 32'd1);
    chk("t4_full_head", out_pc, 32'h0);
    @(posedge clk_in); #2 out_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      chk("t4_pop_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk_in);
    chk("t4_empty_after_4", 32'(out_valid), 32'd0);
    drain("t4");

    // Flush while waiting on 0x8 (latency 3): stale response drained and dropped
    init_mem();
    do_reset(3);
    er(32'h0); eo(32'h0, 1'b0);
    er(32'h4); eo(32'h4, 1'b0);
    er(32'h8);
    er(32'h100); eo(32'h100, 1'b0);
    er(32'h104); eo(32'h104, 1'b0);
    wait_req(32'h8, "t5_wait_req8");
    @(posedge clk_in); #2 flush_in = 1'b1; flush_pc = 32'h100;
    @(negedge clk_in);
    chk("t5_flush_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk_in); #2 flush_in = 1'b0;
    @(negedge clk_in);
    chk("t5_drain_req", 32'(ic_req), 32'd1);
    chk("t5_drain_addr", ic_addr, 32'h8);
    @(negedge clk_in);
    chk("t5_drain_req2", 32'(ic_req), 32'd1);
    @(negedge clk_in);
    chk("t5_stale_req_drop", 32'(ic_req), 32'd0);
    chk("t5_stale_not_queued", 32'(out_valid), 32'd0);
    drain("t5");

    // Flush coincident with ic_valid, then rdy_in low for 3 cycles mid-wait
    init_mem();
    out_stall = 1'b1;
    do_reset(2);
    er(32'h0); er(32'h4); er(32'h8);
    er(32'h200); eo(32'h200, 1'b0);
    er(32'h204); eo(32'h204, 1'b0);
    er(32'h208); eo(32'h208, 1'b0);
    wait_valid(32'h8, "t6_wait_valid8");
    flush_in = 1'b1; flush_pc = 32'h200;
    #1 chk("t6_flush_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk_in); #2 flush_in = 1'b0;
    @(negedge clk_in);
    chk("t6_idle_after_flush", 32'(ic_req), 32'd0);
    chk("t6_queue_cleared", 32'(out_valid), 32'd0);
    wait_req(32'h208, "t6_wait_req208");
    @(posedge clk_in); #2 rdy_in = 1'b0; out_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk("t6_hold_req", 32'(ic_req), 32'd1);
      chk("t6_hold_addr", ic_addr, 32'h208);
      chk("t6_hold_valid", 32'(out_valid), 32'd1);
      chk("t6_hold_head", out_pc, 32'h200);
    end
    @(posedge clk_in); #2 rdy_in = 1'b1;
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
